// File: rtl/dual_port_mem_responder.sv
// ---------------------------------------------------------------------------
// dual_port_mem_responder
//
// Memory-side responder for the split instruction/data memory interface.
// Each port runs its own IDLE -> BUSY -> RESP -> IDLE sequencer against one
// shared word-addressed array and answers with a one-cycle *_resp pulse a
// fixed number of cycles after it accepts a request.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; latch address/op and load the timer
// BUSY   | timer counting down to terminal count
// RESP   | one-cycle completion: read data driven / write committed
//
// Parameters:
//   ADDR_W    word-index width (array holds 2^ADDR_W 32-bit words)
//   LATENCY   cycles from acceptance to resp, 1..15
//   LFSR_SEED nonzero seed for the stall LFSRs
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_read               fetch request, held until instr_mem_resp
//   instr_mem_address[31:0]  fetch byte address
//   instr_mem_resp           one-cycle completion pulse
//   instr_mem_rdata[31:0]    fetch data, zero outside the resp cycle
//   data_read, data_write    load / store request (both high = store)
//   data_mbe[3:0]            store byte enables, bit i = byte lane i
//   data_mem_address[31:0]   load/store byte address
//   data_mem_wdata[31:0]     store data
//   data_mem_resp            one-cycle completion pulse
//   data_mem_rdata[31:0]     load data, zero outside a load resp cycle
//
// Optional feature: define MEM_RESP_RANDOM_STALL_EN to add 0..3 random
// stall cycles per access from a per-port 8-bit LFSR.
// ---------------------------------------------------------------------------
module dual_port_mem_responder #(
   parameter int          ADDR_W    = 12,
   parameter int          LATENCY   = 2,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_read,
   input  logic [31:0] instr_mem_address,
   output logic        instr_mem_resp,
   output logic [31:0] instr_mem_rdata,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [3:0]  data_mbe,
   input  logic [31:0] data_mem_address,
   input  logic [31:0] data_mem_wdata,
   output logic        data_mem_resp,
   output logic [31:0] data_mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Counter is wide enough for LATENCY-1 (max 14) plus 3 stall cycles.
   localparam logic [4:0] C_LOAD = 5'(LATENCY - 1);

   logic [31:0]       r_mem [0:(1 << ADDR_W) - 1];

   logic [1:0]        r_i_state;
   logic [4:0]        r_i_cnt;
   logic [ADDR_W-1:0] r_i_idx;

   logic [1:0]        r_d_state;
   logic [4:0]        r_d_cnt;
   logic [ADDR_W-1:0] r_d_idx;
   logic              r_d_wr;
   logic [3:0]        r_d_mbe;
   logic [31:0]       r_d_wdata;

   logic [4:0]        w_i_load;
   logic [4:0]        w_d_load;
   logic              w_unused_addr;

   // Address bits outside the word index are deliberately ignored (aliasing).
   assign w_unused_addr = ^{instr_mem_address[31:ADDR_W+2], instr_mem_address[1:0],
                            data_mem_address[31:ADDR_W+2], data_mem_address[1:0]};

`ifdef MEM_RESP_RANDOM_STALL_EN
   logic [7:0] r_i_lfsr;
   logic [7:0] r_d_lfsr;

   // Fibonacci LFSR, taps 8,6,5,4; free-running whenever out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i_lfsr <= LFSR_SEED;
         r_d_lfsr <= ~LFSR_SEED;
      end else begin
         r_i_lfsr <= {r_i_lfsr[6:0], r_i_lfsr[7] ^ r_i_lfsr[5] ^ r_i_lfsr[4] ^ r_i_lfsr[3]};
         r_d_lfsr <= {r_d_lfsr[6:0], r_d_lfsr[7] ^ r_d_lfsr[5] ^ r_d_lfsr[4] ^ r_d_lfsr[3]};
      end
   end

   assign w_i_load = C_LOAD + {3'b000, r_i_lfsr[1:0]};
   assign w_d_load = C_LOAD + {3'b000, r_d_lfsr[1:0]};
`else
   assign w_i_load = C_LOAD;
   assign w_d_load = C_LOAD;
`endif

   // Instruction port sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i_state <= S_IDLE;
         r_i_cnt   <= '0;
         r_i_idx   <= '0;
      end else begin
         case (r_i_state)
            S_IDLE: begin
               if (instr_read) begin
                  r_i_idx   <= instr_mem_address[ADDR_W+1:2];
                  r_i_cnt   <= w_i_load;
                  r_i_state <= (w_i_load == 5'd0) ? S_RESP : S_BUSY;
               end
            end
            S_BUSY: begin
               // Counter reaches zero on the same edge we enter RESP.
               r_i_cnt <= r_i_cnt - 5'd1;
               if (r_i_cnt == 5'd1) r_i_state <= S_RESP;
            end
            S_RESP:  r_i_state <= S_IDLE;
            default: r_i_state <= S_IDLE;
         endcase
      end
   end

   // Data port sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d_state <= S_IDLE;
         r_d_cnt   <= '0;
         r_d_idx   <= '0;
         r_d_wr    <= 1'b0;
         r_d_mbe   <= '0;
         r_d_wdata <= '0;
      end else begin
         case (r_d_state)
            S_IDLE: begin
               if (data_read || data_write) begin
                  r_d_idx   <= data_mem_address[ADDR_W+1:2];
                  r_d_wr    <= data_write;
                  r_d_mbe   <= data_mbe;
                  r_d_wdata <= data_mem_wdata;
                  r_d_cnt   <= w_d_load;
                  r_d_state <= (w_d_load == 5'd0) ? S_RESP : S_BUSY;
               end
            end
            S_BUSY: begin
               r_d_cnt <= r_d_cnt - 5'd1;
               if (r_d_cnt == 5'd1) r_d_state <= S_RESP;
            end
            S_RESP:  r_d_state <= S_IDLE;
            default: r_d_state <= S_IDLE;
         endcase
      end
   end

   // Store commits on the edge that ends RESP. Reset forces the FSM out of
   // RESP asynchronously, so an interrupted store never reaches this point.
   always_ff @(posedge clk) begin
      if (r_d_state == S_RESP && r_d_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (r_d_mbe[b]) r_mem[r_d_idx][8*b +: 8] <= r_d_wdata[8*b +: 8];
         end
      end
   end

   // Combinational read during RESP: a same-cycle store has not committed
   // yet, which gives read-before-write ordering for the instr port.
   assign instr_mem_resp  = (r_i_state == S_RESP);
   assign instr_mem_rdata = instr_mem_resp ? r_mem[r_i_idx] : 32'h0;
   assign data_mem_resp   = (r_d_state == S_RESP);
   assign data_mem_rdata  = (data_mem_resp && !r_d_wr) ? r_mem[r_d_idx] : 32'h0;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
module tb_dual_port_mem_responder;

   localparam int LAT   = 2;
   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;
   localparam int TMO   = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_read = 1'b0;
   logic [31:0] instr_mem_address = '0;
   logic        instr_mem_resp;
   logic [31:0] instr_mem_rdata;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [3:0]  data_mbe = '0;
   logic [31:0] data_mem_address = '0;
   logic [31:0] data_mem_wdata = '0;
   logic        data_mem_resp;
   logic [31:0] data_mem_rdata;

   // second instance, LATENCY = 1
   logic        l1_instr_read = 1'b0;
   logic [31:0] l1_instr_mem_address = '0;
   logic        l1_instr_mem_resp;
   logic [31:0] l1_instr_mem_rdata;
   logic        l1_data_read = 1'b0;
   logic        l1_data_write = 1'b0;
   logic [3:0]  l1_data_mbe = '0;
   logic [31:0] l1_data_mem_address = '0;
   logic [31:0] l1_data_mem_wdata = '0;
   logic        l1_data_mem_resp;
   logic [31:0] l1_data_mem_rdata;

   logic [31:0] ref_mem [DEPTH];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   dual_port_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .instr_read(instr_read), .instr_mem_address(instr_mem_address),
      .instr_mem_resp(instr_mem_resp), .instr_mem_rdata(instr_mem_rdata),
      .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
      .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
      .data_mem_resp(data_mem_resp), .data_mem_rdata(data_mem_rdata)
   );

   dual_port_mem_responder #(.ADDR_W(AW), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst),
      .instr_read(l1_instr_read), .instr_mem_address(l1_instr_mem_address),
      .instr_mem_resp(l1_instr_mem_resp), .instr_mem_rdata(l1_instr_mem_rdata),
      .data_read(l1_data_read), .data_write(l1_data_write), .data_mbe(l1_data_mbe),
      .data_mem_address(l1_data_mem_address), .data_mem_wdata(l1_data_mem_wdata),
      .data_mem_resp(l1_data_mem_resp), .data_mem_rdata(l1_data_mem_rdata)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] addr);
      return int'((addr >> 2) % DEPTH);
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] wd,
                                       input logic [3:0] mbe);
      int i;
      i = idx_of(addr);
      for (int b = 0; b < 4; b++)
         if (mbe[b]) ref_mem[i][8*b +: 8] = wd[8*b +: 8];
   endfunction

   task automatic check_lat(input string tag, input int lat);
`ifdef MEM_RESP_RANDOM_STALL_EN
      check_val(tag, (lat >= LAT && lat <= LAT + 3), 1);
`else
      check_val(tag, lat, LAT);
`endif
   endtask

   // Starts at a negedge, raises the request, counts edges until resp.
   task automatic instr_access(input logic [31:0] addr, output logic [31:0] rd, output int lat);
      @(negedge clk);
      instr_read = 1'b1;
      instr_mem_address = addr;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!instr_mem_resp && lat < TMO);
      if (lat >= TMO) check_val("instr_timeout", 0, 1);
      rd = instr_mem_rdata;
      instr_read = 1'b0;
      @(negedge clk);
      check_val("instr_pulse", instr_mem_resp, 0);
      check_val("instr_rdata_idle", instr_mem_rdata, 0);
   endtask

   task automatic data_access(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] mbe,
                              output logic [31:0] rd, output int lat);
      @(negedge clk);
      data_read = rd_en;
      data_write = wr_en;
      data_mem_address = addr;
      data_mem_wdata = wd;
      data_mbe = mbe;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!data_mem_resp && lat < TMO);
      if (lat >= TMO) check_val("data_timeout", 0, 1);
      rd = data_mem_rdata;
      data_read = 1'b0;
      data_write = 1'b0;
      @(negedge clk);
      check_val("data_pulse", data_mem_resp, 0);
      check_val("data_rdata_idle", data_mem_rdata, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd, ird;
      int          lat, ilat;
      int          stall_seen [4];
      int          last_pulse, pulses;

      for (int i = 0; i < 4; i++) stall_seen[i] = 0;
      for (int i = 0; i < DEPTH; i++) begin
         u_dut.r_mem[i]    <= 32'h0;
         u_dut_l1.r_mem[i] <= 32'h0;
         ref_mem[i] = 32'h0;
      end
      #1;
      u_dut.r_mem[4] <= 32'hDEAD_BEEF;
      ref_mem[4] = 32'hDEAD_BEEF;

      // reset with requests held high
      instr_read = 1'b1; data_read = 1'b1; data_write = 1'b1; data_mbe = 4'hF;
      repeat (3) @(negedge clk);
      check_val("rst_iresp", instr_mem_resp, 0);
      check_val("rst_dresp", data_mem_resp, 0);
      check_val("rst_irdata", instr_mem_rdata, 0);
      check_val("rst_drdata", data_mem_rdata, 0);
      instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // first fetch
      instr_access(32'h0000_0010, rd, lat);
      check_val("fetch_data", rd, 32'hDEAD_BEEF);
      check_lat("fetch_lat", lat);

      // byte-enabled store, then mbe = 0 store
      @(negedge clk);
      u_dut.r_mem[16] <= 32'hFFFF_FFFF;
      ref_mem[16] = 32'hFFFF_FFFF;
      data_access(1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'b0101, rd, lat);
      model_write(32'h40, 32'h1122_3344, 4'b0101);
      check_lat("store_lat", lat);
      data_access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd, lat);
      check_val("mbe_merge", rd, 32'hFF22_FF44);
      check_val("mbe_merge_model", rd, ref_mem[16]);
      data_access(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, rd, lat);
      data_access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd, lat);
      check_val("mbe_zero", rd, 32'hFF22_FF44);

      // read and write both high -> write, rdata 0
      data_access(1'b1, 1'b1, 32'h80, 32'h1234_5678, 4'hF, rd, lat);
      model_write(32'h80, 32'h1234_5678, 4'hF);
      check_val("rw_both_rdata", rd, 0);
      data_access(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, rd, lat);
      check_val("rw_both_store", rd, 32'h1234_5678);

      // same-cycle RESP on both ports, index 8
      @(negedge clk);
      u_dut.r_mem[8] <= 32'hAAAA_AAAA;
      ref_mem[8] = 32'hAAAA_AAAA;
      fork
         instr_access(32'h20, ird, ilat);
         data_access(1'b0, 1'b1, 32'h20, 32'h5555_5555, 4'hF, rd, lat);
      join
`ifndef MEM_RESP_RANDOM_STALL_EN
      check_val("rbw_same_lat", ilat, lat);
      check_val("rbw_instr", ird, 32'hAAAA_AAAA);
`endif
      model_write(32'h20, 32'h5555_5555, 4'hF);
      data_access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, lat);
      check_val("rbw_after", rd, 32'h5555_5555);

      // reset during BUSY of a store
      @(negedge clk);
      data_write = 1'b1; data_mem_address = 32'h50; data_mem_wdata = 32'hCAFE_BABE; data_mbe = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("rst_busy_resp", data_mem_resp, 0);
      data_write = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_val("rst_busy_noresp", data_mem_resp, 0);
      end
      rst = 1'b0;
      data_access(1'b1, 1'b0, 32'h50, 32'h0, 4'h0, rd, lat);
      check_val("rst_busy_word", rd, ref_mem[20]);
      check_lat("rst_after_lat", lat);

      // LATENCY=1 instance, data_read held, aliased address
      @(negedge clk);
      u_dut_l1.r_mem[16] <= 32'h600D_F00D;
      @(negedge clk);
      l1_data_read = 1'b1;
      l1_data_mem_address = 32'h4000_0040;
      last_pulse = -1;
      pulses = 0;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (l1_data_mem_resp) begin
            check_val("l1_alias_data", l1_data_mem_rdata, 32'h600D_F00D);
            if (last_pulse >= 0) begin
`ifdef MEM_RESP_RANDOM_STALL_EN
               check_val("l1_gap_range", (c - last_pulse >= 2 && c - last_pulse <= 5), 1);
`else
               check_val("l1_gap", c - last_pulse, 2);
`endif
            end
            last_pulse = c;
            pulses++;
         end else begin
            check_val("l1_rdata_idle", l1_data_mem_rdata, 0);
         end
      end
      l1_data_read = 1'b0;
`ifndef MEM_RESP_RANDOM_STALL_EN
      check_val("l1_pulses", pulses, 12);
`else
      check_val("l1_pulses_min", pulses >= 4, 1);
`endif

      // randomized traffic against the reference model
      for (int n = 0; n < 1000; n++) begin
         int          op, ix;
         logic [31:0] addr, wd;
         logic [3:0]  mbe;
         op   = $urandom_range(0, 3);
         ix   = $urandom_range(0, 63);
         addr = ($urandom & 32'hFFFF_C000) | (ix << 2) | $urandom_range(0, 3);
         wd   = $urandom;
         mbe  = 4'($urandom_range(0, 15));
         if (op == 0) begin
            instr_access(addr, rd, lat);
            check_val("rnd_instr", rd, ref_mem[ix]);
         end else if (op == 3) begin
            data_access(1'b0, 1'b1, addr, wd, mbe, rd, lat);
            model_write(addr, wd, mbe);
         end else begin
            data_access(1'b1, 1'b0, addr, 32'h0, 4'h0, rd, lat);
            check_val("rnd_load", rd, ref_mem[ix]);
         end
         check_lat("rnd_lat", lat);
         if (lat >= LAT && lat <= LAT + 3) stall_seen[lat - LAT]++;
      end
`ifdef MEM_RESP_RANDOM_STALL_EN
      for (int s = 0; s < 4; s++) check_val("stall_cover", stall_seen[s] > 0, 1);
`else
      check_val("no_stall", stall_seen[0], 1000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
